i2s_adc_rx: RTL

Parametrised I2S capture engine for the WM8731 ADC path, replacing the fixed 16-bit left-only receiver.
- Runs on the bit-clock domain `clk`.
- Aligns to AUD_ADCLRCK and deserialises MSB-first words of DATA_W bits, in left-only, right-only or stereo mode.
- Buffers the words in a DEPTH-entry first-word-fall-through FIFO with a valid/ready output.
- Feeds the recorder/SRAM writer under top-level control.

---
 rtl/i2s_adc_rx.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/i2s_adc_rx.sv
// rtl/i2s_adc_rx.sv - I2S ADC capture engine with first-word-fall-through output FIFO
// Define I2S_ADC_RX_LJ_EN for left-justified framing (MSB sampled on the lrck edge cycle).
module i2s_adc_rx #(
  parameter int DATA_W  = 16,
  parameter int DEPTH   = 4,
  parameter int CH_MODE = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    AUD_ADCLRCK,
  input  logic                    AUD_ADCDAT,
  output logic [DATA_W-1:0]       out_data,
  output logic                    out_chan,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [$clog2(DEPTH):0]  fifo_level,
  output logic                    overflow,
  output logic                    frame_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(DATA_W);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);
`ifdef I2S_ADC_RX_LJ_EN
  localparam logic [CW-1:0] START = CW'(1);
`else
  localparam logic [CW-1:0] START = CW'(0);
`endif

  typedef enum logic [1:0] {IDLE, SYNC, SHIFT, WAIT} state_t;

  state_t            state;
  logic              lrck_d;
  logic              enable_d;
  logic              cur_chan;
  logic [CW-1:0]     bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W:0]   mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;

  logic              is_edge;
  logic              edge_chan;
  logic              wanted;
  logic              sync_ok;
  logic              push;
  logic              do_pop;
  logic              accept;
  logic [DATA_W-1:0] push_word;
  logic [AW-1:0]     rd_next;

  always_comb begin
    is_edge   = AUD_ADCLRCK != lrck_d;
    edge_chan = AUD_ADCLRCK;
    case (CH_MODE)
      0:       wanted = !edge_chan;
      1:       wanted = edge_chan;
      default: wanted = 1'b1;
    endcase
    // Stereo capture must begin on a left half-frame so L always precedes R.
    sync_ok   = is_edge && ((CH_MODE == 2) ? !edge_chan : wanted);
    push      = enable && (state == SHIFT) && (bit_cnt == LAST);
    push_word = {shreg[DATA_W-2:0], AUD_ADCDAT};
    do_pop    = out_valid && out_ready;
    accept    = push && ((fifo_level != LW'(DEPTH)) || do_pop);
    rd_next   = rd_ptr + AW'(1);
  end

  assign out_valid = fifo_level != '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      lrck_d    <= 1'b0;
      enable_d  <= 1'b0;
      cur_chan  <= 1'b0;
      bit_cnt   <= '0;
      shreg     <= '0;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      lrck_d    <= AUD_ADCLRCK;
      enable_d  <= enable;
      frame_err <= 1'b0;
      // The word is simply the last DATA_W bits seen; bit_cnt decides when it is complete.
      shreg     <= push_word;
      if (push && !accept)
        overflow <= 1'b1;
      else if (enable && !enable_d)
        overflow <= 1'b0;

      if (!enable) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: state <= SYNC;
          SYNC: begin
            if (sync_ok) begin
              state    <= SHIFT;
              cur_chan <= edge_chan;
              bit_cnt  <= START;
            end
          end
          SHIFT, WAIT: begin
            if (is_edge) begin
              if (state == SHIFT && bit_cnt != LAST)
                frame_err <= 1'b1;
              if (wanted) begin
                state    <= SHIFT;
                cur_chan <= edge_chan;
                bit_cnt  <= START;
              end else begin
                state <= WAIT;
              end
            end else if (state == SHIFT) begin
              if (bit_cnt == LAST)
                state <= WAIT;
              else
                bit_cnt <= bit_cnt + CW'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept)
      mem[wr_ptr] <= {cur_chan, push_word};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      out_data   <= '0;
      out_chan   <= 1'b0;
    end else begin
      if (accept)
        wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)
        rd_ptr <= rd_next;
      fifo_level <= fifo_level + LW'(accept) - LW'(do_pop);
      // Head register holds its value when the FIFO drains empty.
      if (do_pop && fifo_level > LW'(1))
        {out_chan, out_data} <= mem[rd_next];
      else if (accept && (fifo_level == '0 || do_pop))
        {out_chan, out_data} <= {cur_chan, push_word};
    end
  end

endmodule
